duty_ramp: RTL and testbench

Slew-rate limiter between the control loop and the motor driver. It accepts signed 12-bit left/right duty commands every clock and produces ramped signed 12-bit duties, which feed the motor driver's lft_duty/rght_duty inputs directly. Each channel moves toward its target by a bounded step per prescaler tick. A sign reversal forces the channel to pass through zero and dwell there before going the other way. Outputs are clamped so that -2048 never reaches the driver's magnitude logic.

---
 rtl/duty_ramp.sv | 156 +++++++++++++++
 tb/tb_duty_ramp.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/duty_ramp.sv
// Per-channel duty slew limiter with a forced pass through zero on direction reversal.
// Optional bypass input is enabled with `define DUTY_RAMP_BYPASS_EN.
module duty_ramp #(
  parameter int unsigned STEP_DIV  = 1024,
  parameter int unsigned STEP      = 16,
  parameter int unsigned ZERO_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
`ifdef DUTY_RAMP_BYPASS_EN
  input  logic               bypass,
`endif
  input  logic signed [11:0] lft_cmd,
  input  logic signed [11:0] rght_cmd,
  output logic signed [11:0] lft_duty,
  output logic signed [11:0] rght_duty,
  output logic               at_tgt
);

  localparam int unsigned DW = 12;
  localparam int unsigned SW = DW + 1;
  localparam int unsigned PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned HW = (ZERO_HOLD > 0) ? $clog2(ZERO_HOLD + 1) : 1;
  localparam logic [SW-1:0] STEP_MAX = SW'(STEP);
  localparam logic signed [DW-1:0] NEG_FULL = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0] NEG_CLAMP = {1'b1, {(DW-2){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    REV  = 2'd1,
    HOLD = 2'd2
  } state_t;

  logic [PW-1:0]          pre_q;
  logic                   tick;
  state_t                 state_q [2];
  state_t                 state_d [2];
  logic signed [DW-1:0]   duty_q  [2];
  logic signed [DW-1:0]   duty_d  [2];
  logic signed [DW-1:0]   tgt     [2];
  logic signed [DW-1:0]   cmd     [2];
  logic [HW-1:0]          hold_q  [2];
  logic [HW-1:0]          hold_d  [2];
  logic                   at_tgt_d;

  assign cmd[0]    = lft_cmd;
  assign cmd[1]    = rght_cmd;
  assign lft_duty  = duty_q[0];
  assign rght_duty = duty_q[1];
  assign tick      = (pre_q == PW'(STEP_DIV - 1));

  // Move cur toward dst by at most STEP without overshooting.
  function automatic logic signed [DW-1:0] step_to(input logic signed [DW-1:0] cur,
                                                   input logic signed [DW-1:0] dst);
    logic [SW-1:0] diff;
    logic [SW-1:0] mag;
    logic [SW-1:0] amt;
    logic [SW-1:0] res;
    diff = {dst[DW-1], dst} - {cur[DW-1], cur};
    mag  = diff[DW] ? (~diff + SW'(1)) : diff;
    amt  = (mag > STEP_MAX) ? STEP_MAX : mag;
    res  = diff[DW] ? ({cur[DW-1], cur} - amt) : ({cur[DW-1], cur} + amt);
    return res[DW-1:0];
  endfunction

  // Zero carries no sign, so only two non-zero values can disagree.
  function automatic logic opposite(input logic signed [DW-1:0] a,
                                    input logic signed [DW-1:0] b);
    return (a != '0) && (b != '0) && (a[DW-1] != b[DW-1]);
  endfunction

  // State, duty, hold counter and prescaler registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q  <= '0;
      at_tgt <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= RUN;
        duty_q[i]  <= '0;
        hold_q[i]  <= '0;
      end
    end else begin
      pre_q  <= tick ? '0 : pre_q + PW'(1);
      at_tgt <= at_tgt_d;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        duty_q[i]  <= duty_d[i];
        hold_q[i]  <= hold_d[i];
      end
    end
  end

  // Per-channel next-state, next-duty and settled flag.
  always_comb begin
    at_tgt_d = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tgt[i]     = en ? cmd[i] : '0;
      state_d[i] = state_q[i];
      duty_d[i]  = duty_q[i];
      hold_d[i]  = hold_q[i];
      if (tgt[i] == NEG_FULL) begin
        tgt[i] = NEG_CLAMP;
      end

      case (state_q[i])
        RUN: begin
          if (opposite(duty_q[i], tgt[i])) begin
            state_d[i] = REV;
          end else if (tick) begin
            duty_d[i] = step_to(duty_q[i], tgt[i]);
          end
        end
        REV: begin
          if (!opposite(duty_q[i], tgt[i])) begin
            state_d[i] = RUN;
          end else if (tick) begin
            duty_d[i] = step_to(duty_q[i], '0);
            if (duty_d[i] == '0) begin
              hold_d[i]  = '0;
              state_d[i] = (ZERO_HOLD == 0) ? RUN : HOLD;
            end
          end
        end
        HOLD: begin
          duty_d[i] = '0;
          if (tick) begin
            if (hold_q[i] + HW'(1) == HW'(ZERO_HOLD)) begin
              state_d[i] = RUN;
              hold_d[i]  = '0;
            end else begin
              hold_d[i] = hold_q[i] + HW'(1);
            end
          end
        end
        default: begin
          state_d[i] = RUN;
          hold_d[i]  = '0;
        end
      endcase

`ifdef DUTY_RAMP_BYPASS_EN
      if (bypass) begin
        state_d[i] = RUN;
        hold_d[i]  = '0;
        duty_d[i]  = tgt[i];
      end
`endif

      if ((state_d[i] != RUN) || (duty_d[i] != tgt[i])) begin
        at_tgt_d = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_duty_ramp.sv
// Table-driven scoreboard bench for duty_ramp: ramp, reversal, abort, en drop, reset in HOLD, clamp.
module tb_duty_ramp;

  logic clk = 1'b0;
  logic rst_n, en, rst2_n, en2;
  logic signed [11:0] lft_cmd, rght_cmd, lft_duty, rght_duty;
  logic signed [11:0] lcmd2, rcmd2, lduty2, rduty2;
  logic at_tgt, at2;
`ifdef DUTY_RAMP_BYPASS_EN
  logic bypass, bypass2;
`endif

  duty_ramp #(.STEP_DIV(4), .STEP(16), .ZERO_HOLD(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
`ifdef DUTY_RAMP_BYPASS_EN
    .bypass(bypass),
`endif
    .lft_cmd(lft_cmd), .rght_cmd(rght_cmd),
    .lft_duty(lft_duty), .rght_duty(rght_duty), .at_tgt(at_tgt)
  );

  duty_ramp #(.STEP_DIV(1), .STEP(2047), .ZERO_HOLD(2)) dut_clamp (
    .clk(clk), .rst_n(rst2_n), .en(en2),
`ifdef DUTY_RAMP_BYPASS_EN
    .bypass(bypass2),
`endif
    .lft_cmd(lcmd2), .rght_cmd(rcmd2),
    .lft_duty(lduty2), .rght_duty(rduty2), .at_tgt(at2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned        clks;
    logic               rst_n;
    logic               en;
    logic signed [11:0] lcmd;
    logic signed [11:0] rcmd;
    logic signed [11:0] exp_l;
    logic signed [11:0] exp_r;
    logic               exp_at;
  } vec_t;

  typedef struct {
    string              name;
    logic signed [11:0] l;
    logic signed [11:0] r;
    logic               at;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic void add(int unsigned c, logic rn, logic e, int lc, int rc,
                              int el, int er, logic ea);
    vec_t v;
    v.clks = c; v.rst_n = rn; v.en = e;
    v.lcmd = 12'(lc); v.rcmd = 12'(rc);
    v.exp_l = 12'(el); v.exp_r = 12'(er); v.exp_at = ea;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, logic signed [11:0] act, logic signed [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk1(string name, logic act, logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic adv(int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(string name, int l, int r, logic at);
    exp_t e;
    e.name = name; e.l = 12'(l); e.r = 12'(r); e.at = at;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(logic signed [11:0] l, logic signed [11:0] r, logic at);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries, expected 1");
    end else begin
      e = sb.pop_front();
      chk({e.name, "_lft"}, l, e.l);
      chk({e.name, "_rght"}, r, e.r);
      chk1({e.name, "_at"}, at, e.at);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; lft_cmd = 12'sd500; rght_cmd = '0;
    rst2_n = 1'b0; en2 = 1'b1; lcmd2 = 12'h800; rcmd2 = 12'h7FF;
`ifdef DUTY_RAMP_BYPASS_EN
    bypass = 1'b0; bypass2 = 1'b0;
`endif

    // clks, rst_n, en, lcmd, rcmd, exp_l, exp_r, exp_at
    add(1, 0, 1, 500, 0, 0, 0, 0);
    add(1, 0, 1, 500, 0, 0, 0, 0);
    add(1, 0, 1, 500, 0, 0, 0, 0);
    add(3, 1, 1, 500, 0, 0, 0, 0);
    add(1, 1, 1, 500, 0, 16, 0, 0);
    add(4, 1, 0, 500, 0, 0, 0, 1);
    // up ramp to 100
    add(4, 1, 1, 100, 0, 16, 0, 0);
    add(4, 1, 1, 100, 0, 32, 0, 0);
    add(4, 1, 1, 100, 0, 48, 0, 0);
    add(4, 1, 1, 100, 0, 64, 0, 0);
    add(4, 1, 1, 100, 0, 80, 0, 0);
    add(4, 1, 1, 100, 0, 96, 0, 0);
    add(4, 1, 1, 100, 0, 100, 0, 1);
    add(4, 1, 1, 100, 0, 100, 0, 1);
    // down to 40
    add(4, 1, 1, 40, 0, 84, 0, 0);
    add(4, 1, 1, 40, 0, 68, 0, 0);
    add(4, 1, 1, 40, 0, 52, 0, 0);
    add(4, 1, 1, 40, 0, 40, 0, 1);
    // reversal 40 -> -40 with two-tick dwell
    add(4, 1, 1, -40, 0, 24, 0, 0);
    add(4, 1, 1, -40, 0, 8, 0, 0);
    add(4, 1, 1, -40, 0, 0, 0, 0);
    add(4, 1, 1, -40, 0, 0, 0, 0);
    add(4, 1, 1, -40, 0, 0, 0, 0);
    add(4, 1, 1, -40, 0, -16, 0, 0);
    add(4, 1, 1, -40, 0, -32, 0, 0);
    add(4, 1, 1, -40, 0, -40, 0, 1);
    // reversal -40 -> 40
    add(4, 1, 1, 40, 0, -24, 0, 0);
    add(4, 1, 1, 40, 0, -8, 0, 0);
    add(4, 1, 1, 40, 0, 0, 0, 0);
    add(4, 1, 1, 40, 0, 0, 0, 0);
    add(4, 1, 1, 40, 0, 0, 0, 0);
    add(4, 1, 1, 40, 0, 16, 0, 0);
    add(4, 1, 1, 40, 0, 32, 0, 0);
    add(4, 1, 1, 40, 0, 40, 0, 1);
    // reversal abort: back to +40 before reaching zero
    add(4, 1, 1, -40, 0, 24, 0, 0);
    add(4, 1, 1, 40, 0, 40, 0, 1);
    // reverse to -64 while right ramps to 50
    add(4, 1, 1, -64, 50, 24, 16, 0);
    add(4, 1, 1, -64, 50, 8, 32, 0);
    add(4, 1, 1, -64, 50, 0, 48, 0);
    add(4, 1, 1, -64, 50, 0, 50, 0);
    add(4, 1, 1, -64, 50, 0, 50, 0);
    add(4, 1, 1, -64, 50, -16, 50, 0);
    add(4, 1, 1, -64, 50, -32, 50, 0);
    add(4, 1, 1, -64, 50, -48, 50, 0);
    add(4, 1, 1, -64, 50, -64, 50, 1);
    // en drop: both channels decay to zero, no dwell
    add(4, 1, 0, -64, 50, -48, 34, 0);
    add(4, 1, 0, -64, 50, -32, 18, 0);
    add(4, 1, 0, -64, 50, -16, 2, 0);
    add(4, 1, 0, -64, 50, 0, 0, 1);
    // reset while in HOLD
    add(4, 1, 1, 16, 0, 16, 0, 1);
    add(4, 1, 1, -16, 0, 0, 0, 0);
    add(1, 1, 1, -16, 0, 0, 0, 0);
    add(1, 0, 1, -16, 0, 0, 0, 0);
    add(3, 1, 1, -16, 0, 0, 0, 0);
    add(1, 1, 1, -16, 0, -16, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n    = vecs[i].rst_n;
      en       = vecs[i].en;
      lft_cmd  = vecs[i].lcmd;
      rght_cmd = vecs[i].rcmd;
      push($sformatf("row%0d", i), int'(vecs[i].exp_l), int'(vecs[i].exp_r), vecs[i].exp_at);
      adv(vecs[i].clks);
      pop_cmp(lft_duty, rght_duty, at_tgt);
    end

    // clamp instance: tick every clock, full-scale step
    rst2_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push($sformatf("clamp%0d", k), -2047, 2047, 1'b1);
      adv(1);
      pop_cmp(lduty2, rduty2, at2);
    end
    rcmd2 = 12'h800;
    push("clamp_rev0", -2047, 2047, 1'b0); adv(1); pop_cmp(lduty2, rduty2, at2);
    push("clamp_rev1", -2047, 0, 1'b0);    adv(1); pop_cmp(lduty2, rduty2, at2);
    push("clamp_rev2", -2047, 0, 1'b0);    adv(1); pop_cmp(lduty2, rduty2, at2);
    push("clamp_rev3", -2047, 0, 1'b0);    adv(1); pop_cmp(lduty2, rduty2, at2);
    push("clamp_rev4", -2047, -2047, 1'b1); adv(1); pop_cmp(lduty2, rduty2, at2);

`ifdef DUTY_RAMP_BYPASS_EN
    bypass = 1'b1; en = 1'b1; lft_cmd = -12'sd300; rght_cmd = 12'sd100;
    push("byp_on", -300, 100, 1'b1);
    adv(1);
    pop_cmp(lft_duty, rght_duty, at_tgt);
    bypass = 1'b0;
    push("byp_off", -300, 100, 1'b1);
    adv(4);
    pop_cmp(lft_duty, rght_duty, at_tgt);
    lft_cmd = -12'sd200;
    push("byp_resume", -284, 100, 1'b0);
    adv(4);
    pop_cmp(lft_duty, rght_duty, at_tgt);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
